seven_seg_mux: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/seven_seg_pkg.sv | 25 ++
 rtl/seven_seg_decoder.sv | 9 +
 rtl/seven_seg_mux.sv | 56 +++++
 tb/tb_seven_seg_mux.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment constants and the hex-to-7-segment table
package seven_seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hex_to_seg(logic [3:0] hex);
    case (hex)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction
endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: combinational hex nibble to active-low segment pattern
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(hex);
endmodule

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: scanned multi-digit 7-segment driver with blanking and frame-synchronous updates
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_CNT  = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    load_i,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_o,
  output logic                    pending_o
);
  localparam int CW = REFRESH_CNT > 1 ? $clog2(REFRESH_CNT) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] dig_sh;
  logic [NUM_DIGITS-1:0]   blank_sh;
  logic [3:0]              nib;
  logic [6:0]              dec;
  logic                    slot_end, wrap, dark, capture;
  assign slot_end = cnt == CW'(REFRESH_CNT - 1);
  assign wrap     = slot_end && idx == IW'(NUM_DIGITS - 1);
  assign dark     = cnt < CW'(BLANK_CYCLES);
  assign capture  = wrap && (pending_o || load_i);
  assign nib      = dig_sh[4*idx +: 4];
  seven_seg_decoder u_dec (.hex(nib), .seg(dec));
  // Scan divider, tear-free shadow capture at frame start, and registered pin drive
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      idx       <= '0;
      dig_sh    <= '0;
      blank_sh  <= '1;
      pending_o <= 1'b0;
      frame_o   <= 1'b0;
      seg       <= SEG_BLANK;
      anode     <= '1;
    end else begin
      cnt       <= slot_end ? '0 : cnt + 1'b1;
      idx       <= wrap ? '0 : slot_end ? idx + 1'b1 : idx;
      frame_o   <= wrap;
      pending_o <= !wrap && (pending_o || load_i);
      dig_sh    <= capture ? digits_i : dig_sh;
      blank_sh  <= capture ? blank_i : blank_sh;
      anode     <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
      seg       <= (dark || blank_sh[idx]) ? SEG_BLANK : dec;
    end
  end
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: randomized self-checking bench against a cycle-count reference model
module tb_seven_seg_mux;
  localparam int N = 4, R = 8, B = 2, P = N * R;
  logic clk = 0, reset = 0, load_i = 0;
  logic [15:0] digits_i = '0;
  logic [3:0] blank_i = '0;
  logic [6:0] seg;
  logic [3:0] anode;
  logic frame_o, pending_o;
  int checks = 0, passed = 0, n = 0;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] m_dig [4];
  logic [3:0] m_blank = '1;
  logic m_pend = 0;
  logic [6:0] e_seg = 7'h7F;
  logic [3:0] e_anode = 4'hF;
  logic e_frame = 0, e_pend = 0;

  seven_seg_mux #(.NUM_DIGITS(N), .REFRESH_CNT(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .digits_i(digits_i), .blank_i(blank_i), .load_i(load_i),
    .seg(seg), .anode(anode), .frame_o(frame_o), .pending_o(pending_o));

  always #5 clk = ~clk;

  // One clock edge: model predicts outputs from elapsed cycles and its own shadow copy
  task automatic tick();
    int pos, s, c;
    bit fe;
    @(posedge clk);
    if (!reset) begin
      n = 0;
      foreach (m_dig[k]) m_dig[k] = 4'h0;
      m_blank = '1; m_pend = 0;
      e_seg = 7'h7F; e_anode = 4'hF; e_frame = 0; e_pend = 0;
    end else begin
      pos = n % P; s = pos / R; c = pos % R;
      fe = ((n + 1) % P) == 0;
      e_anode = c < B ? 4'hF : 4'hF ^ (4'b1 << s);
      e_seg = (c < B || m_blank[s]) ? 7'h7F : seg_tab[m_dig[s]];
      e_frame = fe;
      if (fe && (m_pend || load_i)) begin
        for (int k = 0; k < N; k++) m_dig[k] = digits_i[4*k +: 4];
        m_blank = blank_i;
      end
      m_pend = !fe && (m_pend || load_i);
      e_pend = m_pend;
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({seg, anode, frame_o, pending_o} !== {7'b1111111, 4'b1111, 1'b0, 1'b0})
        $display("FAIL reset cyc%0d got %b want %b", i, {seg, anode, frame_o, pending_o}, 13'b1111111_1111_0_0);
      else passed++;
    end
  endtask

  task automatic test_idle_frame();
    int first = 0;
    reset = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (frame_o === 1'b1 && first == 0) first = i;
      checks++;
      if ({seg, anode, frame_o, pending_o} !== {e_seg, e_anode, e_frame, e_pend})
        $display("FAIL idle cyc%0d got %b want %b", i, {seg, anode, frame_o, pending_o}, {e_seg, e_anode, e_frame, e_pend});
      else passed++;
    end
    checks++;
    if (first !== 32) $display("FAIL first_frame got %0d want 32", first);
    else passed++;
  endtask

  task automatic test_load_mid_frame();
    int waited = 0;
    digits_i = 16'hF830; blank_i = 4'b0000; load_i = 1;
    tick();
    load_i = 0;
    checks++;
    if (pending_o !== 1'b1) $display("FAIL pending_set got %b want 1", pending_o);
    else passed++;
    while (frame_o !== 1'b1 && waited < 2 * P) begin
      tick();
      waited++;
      checks++;
      if ({seg, anode, frame_o, pending_o} !== {e_seg, e_anode, e_frame, e_pend})
        $display("FAIL load_wait cyc%0d got %b want %b", waited, {seg, anode, frame_o, pending_o}, {e_seg, e_anode, e_frame, e_pend});
      else passed++;
    end
    checks++;
    if (frame_o !== 1'b1 || pending_o !== 1'b0) $display("FAIL load_frame got frame=%b pend=%b want 1 0", frame_o, pending_o);
    else passed++;
    digits_i = $urandom;
    for (int i = 0; i < P + 2; i++) begin
      tick();
      checks++;
      if ({seg, anode, frame_o, pending_o} !== {e_seg, e_anode, e_frame, e_pend})
        $display("FAIL load_scan cyc%0d got %b want %b", i, {seg, anode, frame_o, pending_o}, {e_seg, e_anode, e_frame, e_pend});
      else passed++;
      if (anode === 4'b0111) begin
        checks++;
        if (seg !== 7'b0001110) $display("FAIL slot3_F got %b want 0001110", seg);
        else passed++;
      end
    end
  endtask

  task automatic test_no_tear();
    digits_i = 16'h1111; blank_i = 4'b0000; load_i = 1;
    tick();
    load_i = 0;
    for (int i = 0; i < 2 * P && frame_o !== 1'b1; i++) tick();
    digits_i = 16'h2222;
    for (int i = 0; i < 2 * P; i++) begin
      tick();
      checks++;
      if ({seg, anode, frame_o, pending_o} !== {e_seg, e_anode, e_frame, e_pend} ||
          (seg !== 7'b1111111 && seg !== 7'b1111001))
        $display("FAIL no_tear cyc%0d got %b want %b", i, {seg, anode, frame_o, pending_o}, {e_seg, e_anode, e_frame, e_pend});
      else passed++;
    end
  endtask

  task automatic test_frame_edge_load();
    for (int i = 0; i < 2 * P && n % P != P - 1; i++) tick();
    digits_i = $urandom; blank_i = 4'b0100; load_i = 1;
    tick();
    load_i = 0;
    checks++;
    if (frame_o !== 1'b1 || pending_o !== 1'b0) $display("FAIL edge_load got frame=%b pend=%b want 1 0", frame_o, pending_o);
    else passed++;
    digits_i = $urandom; blank_i = $urandom;
    for (int i = 0; i < P; i++) begin
      tick();
      checks++;
      if ({seg, anode, frame_o, pending_o} !== {e_seg, e_anode, e_frame, e_pend} || pending_o !== 1'b0)
        $display("FAIL edge_scan cyc%0d got %b want %b", i, {seg, anode, frame_o, pending_o}, {e_seg, e_anode, e_frame, e_pend});
      else passed++;
      if (anode === 4'b1011) begin
        checks++;
        if (seg !== 7'b1111111) $display("FAIL slot2_blank got %b want 1111111", seg);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      digits_i = $urandom; blank_i = $urandom; load_i = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if ({seg, anode, frame_o, pending_o} !== {e_seg, e_anode, e_frame, e_pend})
        $display("FAIL random cyc%0d got %b want %b", i, {seg, anode, frame_o, pending_o}, {e_seg, e_anode, e_frame, e_pend});
      else passed++;
    end
    load_i = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2 * P && n % P != 0; i++) tick();
    digits_i = $urandom; blank_i = 4'b0000; load_i = 1;
    tick();
    load_i = 0;
    for (int i = 0; i < P && n % P != 2 * R + 3; i++) tick();
    checks++;
    if (pending_o !== 1'b1) $display("FAIL mid_pending got %b want 1", pending_o);
    else passed++;
    reset = 0;
    tick();
    checks++;
    if ({seg, anode, frame_o, pending_o} !== {7'b1111111, 4'b1111, 1'b0, 1'b0})
      $display("FAIL mid_reset got %b want %b", {seg, anode, frame_o, pending_o}, 13'b1111111_1111_0_0);
    else passed++;
    reset = 1;
    for (int i = 0; i < P + 8; i++) begin
      tick();
      checks++;
      if ({seg, anode, frame_o, pending_o} !== {e_seg, e_anode, e_frame, e_pend} || seg !== 7'b1111111)
        $display("FAIL after_reset cyc%0d got %b want %b", i, {seg, anode, frame_o, pending_o}, {e_seg, e_anode, e_frame, e_pend});
      else passed++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_frame();
    test_load_mid_frame();
    test_no_tear();
    test_frame_edge_load();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
